// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding,
// the CUR register layout and the lowest-index priority helper.
package int_ctrl_pkg;

    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_CLR  = 2'd2;
    localparam logic [1:0] OFF_CUR  = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    localparam logic [1:0] MW_NONE = 2'd0;
    localparam logic [1:0] MW_WORD = 2'd1;
    localparam logic [1:0] MW_DMA  = 2'd2;
    localparam logic [1:0] MW_BYTE = 2'd3;

    localparam logic [31:0] DEF_CAUSE_BASE = 32'h0000_0010;

    typedef struct packed {
        logic       active;
        logic [4:0] idx;
    } cur_t;

    localparam cur_t CUR_RESET = '{active: 1'b0, idx: 5'd0};

    function automatic logic [4:0] lowest_index(input logic [15:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = vec[i] ? 5'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_ctrl_edge_sync.sv
// Per-source input conditioning: two-flop synchroniser followed by a rising-edge detector.
module irq_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic rise
);
    // [0] metastable stage, [1] synchronised level, [2] previous synchronised level
    logic [2:0] sync_r;

    // Shift the raw line through the synchroniser and keep one cycle of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], irq};
        end
    end

    assign rise = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, enable mask, lowest-index arbitration,
// registered INTin/INTnum to the CPU and a four-register window on the shared bus.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100,
    parameter logic [31:0] CAUSE_BASE = DEF_CAUSE_BASE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic [31:0]      Addr,
    input  logic             Memread,
    input  logic [1:0]       Memwrite,
    inout  wire  [31:0]      BUS,
    output logic             INTin,
    output logic [31:0]      INTnum
);
    logic [N_SRC-1:0] rise_s, pend_r, mask_r, req_s, lane_s, wdata_s, clr_s, req_shift_s;
    logic             hit_s, commit_s, wr_prev_r, rd_en_s, cur_live_s, int_n, unused_s;
    logic [1:0]       off_s, state_r, state_n;
    logic [4:0]       winner_s;
    logic [31:0]      num_n, rd_data_s;
    cur_t             cur_r, cur_n;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk   (clk),
            .rst_n (rst),
            .irq   (irq[g]),
            .rise  (rise_s[g])
        );
    end

    assign hit_s    = (Addr[31:4] == BASE_ADDR[31:4]);
    assign off_s    = Addr[3:2];
    assign wdata_s  = BUS[N_SRC-1:0];
    // The CPU holds Memwrite for several cycles; only the first cycle after an idle bus commits.
    assign commit_s = hit_s && !wr_prev_r && ((Memwrite == MW_WORD) || (Memwrite == MW_BYTE));
    assign clr_s    = (commit_s && (off_s == OFF_CLR)) ? (wdata_s & lane_s) : {N_SRC{1'b0}};
    assign req_s    = pend_r & mask_r;
    assign winner_s = lowest_index(16'(req_s));
    assign req_shift_s = req_s >> cur_r.idx;
    assign cur_live_s  = req_shift_s[0];
    assign unused_s = ^{Addr[1:0], BUS[31:N_SRC]};

    // Byte writes only reach the sources that live in bits [7:0].
    always_comb begin
        lane_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            lane_s[i] = (Memwrite == MW_WORD) || (i < 8);
        end
    end

    // Pending/mask registers; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r    <= {N_SRC{1'b0}};
            mask_r    <= {N_SRC{1'b0}};
            wr_prev_r <= 1'b0;
        end else begin
            pend_r    <= (pend_r & ~clr_s) | rise_s;
            wr_prev_r <= (Memwrite != MW_NONE);
            if (commit_s && (off_s == OFF_MASK)) begin
                mask_r <= (mask_r & ~lane_s) | (wdata_s & lane_s);
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Next-state logic; GAP is the single low cycle and arbitrates just like IDLE.
    always_comb begin
        state_n = state_r;
        cur_n   = cur_r;
        int_n   = INTin;
        num_n   = INTnum;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (req_s != {N_SRC{1'b0}}) begin
                    state_n = ST_ASSERT;
                    cur_n   = '{active: 1'b1, idx: winner_s};
                    int_n   = 1'b1;
                    num_n   = CAUSE_BASE + 32'(winner_s);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (!cur_live_s) begin
                    state_n      = ST_GAP;
                    cur_n.active = 1'b0;
                    int_n        = 1'b0;
                end else begin
                    state_n = ST_ASSERT;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cur_n   = CUR_RESET;
                int_n   = 1'b0;
            end
        endcase
    end

    // FSM state and the registered CPU-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cur_r   <= CUR_RESET;
            INTin   <= 1'b0;
            INTnum  <= 32'd0;
        end else begin
            state_r <= state_n;
            cur_r   <= cur_n;
            INTin   <= int_n;
            INTnum  <= num_n;
        end
    end

    // Register read mux; CLR always reads as zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (off_s)
            OFF_PEND: rd_data_s = 32'(pend_r);
            OFF_MASK: rd_data_s = 32'(mask_r);
            OFF_CLR:  rd_data_s = 32'd0;
            OFF_CUR:  rd_data_s = {cur_r.active, 26'd0, cur_r.idx};
            default:  rd_data_s = 32'd0;
        endcase
    end

    assign rd_en_s = Memread && hit_s && (Memwrite == MW_NONE);
    assign BUS     = rd_en_s ? rd_data_s : 32'bz;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus a randomized run against a
// spec-level reference model that is advanced once per clock edge.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int          N        = 8;
    localparam logic [31:0] BASE     = 32'hFFFF_0100;
    localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq = '0;
    logic [31:0]   addr = 32'd0;
    logic          memread = 1'b0;
    logic [1:0]    memwrite = 2'd0;
    logic          drv_en = 1'b0;
    logic [31:0]   drv_val = 32'd0;
    wire  [31:0]   bus;
    logic          int_in;
    logic [31:0]   int_num;
    int            n_tests = 0;
    int            n_fail = 0;

    assign bus = drv_en ? drv_val : 32'bz;
    for (genvar gi = 0; gi < 32; gi++) begin : g_pull
        pullup pu (bus[gi]);
    end

    int_ctrl #(.N_SRC(N), .BASE_ADDR(BASE), .CAUSE_BASE(32'h10)) dut (
        .clk(clk), .rst(rst), .irq(irq), .Addr(addr), .Memread(memread),
        .Memwrite(memwrite), .BUS(bus), .INTin(int_in), .INTnum(int_num)
    );

    always #5 clk = ~clk;

    // Reference model state: pending/mask sets, irq samples from previous edges,
    // whether an interrupt is currently presented and which one.
    logic [N-1:0] m_pend, m_mask, m_h0, m_h1, m_h2;
    logic         m_int, m_armed;
    int           m_idx;
    logic [31:0]  m_num;

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_h0 = '0; m_h1 = '0; m_h2 = '0;
        m_int = 1'b0; m_armed = 1'b1; m_idx = 0; m_num = 32'd0;
    endtask

    task automatic model_step();
        logic [N-1:0] req, lanes, clr;
        logic         commit;
        req = m_pend & m_mask;
        if (m_int) begin
            if (!req[m_idx]) m_int = 1'b0;
        end else if (req != '0) begin
            for (int i = N - 1; i >= 0; i--) if (req[i]) m_idx = i;
            m_int = 1'b1;
            m_num = 32'h10 + 32'(m_idx);
        end
        commit  = m_armed && (memwrite == 2'd1 || memwrite == 2'd3) && (addr[31:4] == BASE[31:4]);
        m_armed = (memwrite == 2'd0);
        for (int i = 0; i < N; i++) lanes[i] = (memwrite == 2'd1) || (i < 8);
        clr = '0;
        if (commit && addr[3:2] == 2'd1) m_mask = (m_mask & ~lanes) | (drv_val[N-1:0] & lanes);
        if (commit && addr[3:2] == 2'd2) clr = drv_val[N-1:0] & lanes;
        m_pend = (m_pend & ~clr) | (m_h1 & ~m_h2);
        m_h2 = m_h1; m_h1 = m_h0; m_h0 = irq;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return BUS_IDLE;
        case (a[3:2])
            2'd0:    return 32'(m_pend);
            2'd1:    return 32'(m_mask);
            2'd3:    return {m_int, 26'd0, 5'(m_idx)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] reg_addr(input logic [1:0] off);
        return BASE | {28'd0, off, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_step(); else model_reset();
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input int hold,
                             input logic [1:0] kind);
        addr = reg_addr(off); drv_val = data; drv_en = 1'b1; memwrite = kind;
        repeat (hold) tick();
        memwrite = 2'd0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        addr = a; memread = 1'b1; #1;
        v = bus; memread = 1'b0; #1;
    endtask

    task automatic quiesce();
        irq = '0;
        repeat (4) tick();
        bus_write(OFF_CLR, 32'hFF, 1, 2'd1);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        repeat (3) tick();
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL reset_intin: got %b want 0", int_in); end
        n_tests++; if (int_num !== 32'd0) begin n_fail++; $display("FAIL reset_intnum: got %h want 0", int_num); end
        for (int off = 0; off < 4; off++) begin
            bus_read(reg_addr(2'(off)), v);
            n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", off, v); end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] v;
        bus_write(OFF_MASK, 32'h1, 1, 2'd1);
        irq[0] = 1'b1;
        tick(); tick();
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL basic_pend_early: got %h want 0", v); end
        tick();
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL basic_pend_3clk: got %h want 1", v); end
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL basic_intin_early: got %b want 0", int_in); end
        tick();
        n_tests++; if (int_in !== 1'b1) begin n_fail++; $display("FAIL basic_intin: got %b want 1", int_in); end
        n_tests++; if (int_num !== 32'h10) begin n_fail++; $display("FAIL basic_intnum: got %h want 10", int_num); end
        bus_read(reg_addr(OFF_CUR), v);
        n_tests++; if (v !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_cur: got %h want 80000000", v); end
        irq[0] = 1'b0;
        bus_write(OFF_CLR, 32'h1, 1, 2'd1);
        tick();
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %b want 0", int_in); end
        quiesce();
    endtask

    task automatic test_priority();
        bus_write(OFF_MASK, 32'hFF, 1, 2'd1);
        irq[5] = 1'b1; irq[2] = 1'b1;
        repeat (4) tick();
        n_tests++; if (int_num !== 32'h12 || int_in !== 1'b1) begin n_fail++; $display("FAIL prio_first: got %b/%h want 1/12", int_in, int_num); end
        bus_write(OFF_CLR, 32'h4, 1, 2'd1);
        n_tests++; if (int_in !== 1'b1) begin n_fail++; $display("FAIL prio_hold_on_clr: got %b want 1", int_in); end
        tick();
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %b want 0", int_in); end
        tick();
        n_tests++; if (int_in !== 1'b1 || int_num !== 32'h15) begin n_fail++; $display("FAIL prio_second: got %b/%h want 1/15", int_in, int_num); end
        quiesce();
    endtask

    task automatic test_held_clear();
        logic [31:0] v;
        irq[0] = 1'b1;
        repeat (4) tick();
        irq[0] = 1'b0;
        repeat (3) tick();
        addr = reg_addr(OFF_CLR); drv_val = 32'h1; drv_en = 1'b1; memwrite = 2'd1;
        tick();
        irq[0] = 1'b1;
        tick();
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL held_drop: got %b want 0", int_in); end
        tick(); tick();
        memwrite = 2'd0; drv_en = 1'b0;
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL held_single_commit: got pend %h want bit0 set", v); end
        tick();
        n_tests++; if (int_in !== 1'b1 || int_num !== 32'h10) begin n_fail++; $display("FAIL held_reassert: got %b/%h want 1/10", int_in, int_num); end
        quiesce();
    endtask

    task automatic test_mask_during_assert();
        logic [31:0] v;
        bus_write(OFF_MASK, 32'h08, 1, 2'd1);
        irq[3] = 1'b1;
        repeat (4) tick();
        n_tests++; if (int_in !== 1'b1 || int_num !== 32'h13) begin n_fail++; $display("FAIL mask_first: got %b/%h want 1/13", int_in, int_num); end
        bus_write(OFF_MASK, 32'h0, 1, 2'd1);
        tick();
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL mask_drop: got %b want 0", int_in); end
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v[3] !== 1'b1) begin n_fail++; $display("FAIL mask_pend_kept: got %h want bit3 set", v); end
        repeat (2) tick();
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL mask_stays_low: got %b want 0", int_in); end
        bus_write(OFF_MASK, 32'h08, 1, 2'd1);
        tick();
        n_tests++; if (int_in !== 1'b1 || int_num !== 32'h13) begin n_fail++; $display("FAIL mask_reenable: got %b/%h want 1/13", int_in, int_num); end
    endtask

    task automatic test_bus();
        logic [31:0] v;
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v !== 32'h08) begin n_fail++; $display("FAIL bus_pend: got %h want 08", v); end
        bus_read(reg_addr(OFF_MASK), v);
        n_tests++; if (v !== 32'h08) begin n_fail++; $display("FAIL bus_mask: got %h want 08", v); end
        tick();
        bus_read(reg_addr(OFF_CUR), v);
        n_tests++; if (v !== 32'h8000_0003) begin n_fail++; $display("FAIL bus_cur: got %h want 80000003", v); end
        bus_read(reg_addr(OFF_CLR), v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL bus_clr_reads_zero: got %h want 0", v); end
        tick();
        bus_read(BASE + 32'h10, v);
        n_tests++; if (v !== BUS_IDLE) begin n_fail++; $display("FAIL bus_outside_window: got %h want released", v); end
        addr = reg_addr(OFF_MASK); #1;
        n_tests++; if (bus !== BUS_IDLE) begin n_fail++; $display("FAIL bus_no_memread: got %h want released", bus); end
        bus_write(OFF_MASK, 32'hFF, 2, 2'd2);
        tick();
        bus_read(reg_addr(OFF_MASK), v);
        n_tests++; if (v !== 32'h08) begin n_fail++; $display("FAIL bus_dma_ignored: got %h want 08", v); end
        bus_write(OFF_MASK, 32'hABCD_EF0C, 1, 2'd3);
        tick();
        bus_read(reg_addr(OFF_MASK), v);
        n_tests++; if (v !== 32'h0C) begin n_fail++; $display("FAIL bus_byte_write: got %h want 0c", v); end
        quiesce();
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        bus_write(OFF_MASK, 32'hFF, 1, 2'd1);
        irq[1] = 1'b1;
        tick(); tick();
        bus_write(OFF_CLR, 32'h2, 1, 2'd1);
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v[1] !== 1'b1) begin n_fail++; $display("FAIL set_wins: got pend %h want bit1 set", v); end
        quiesce();
    endtask

    task automatic test_random();
        logic [31:0] v, a, e;
        int wr_left = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            if (wr_left > 0) begin
                wr_left--;
                if (wr_left == 0) begin memwrite = 2'd0; drv_en = 1'b0; end
            end else if ($urandom_range(0, 3) == 0) begin
                addr     = ($urandom_range(0, 7) == 0) ? BASE + 32'h20 : reg_addr(2'($urandom_range(0, 3)));
                drv_val  = $urandom;
                drv_en   = 1'b1;
                case ($urandom_range(0, 3))
                    0:       memwrite = 2'd2;
                    1:       memwrite = 2'd3;
                    default: memwrite = 2'd1;
                endcase
                wr_left = $urandom_range(1, 5);
            end else if ($urandom_range(0, 1) == 0) begin
                a = ($urandom_range(0, 5) == 0) ? BASE - 32'h10 : reg_addr(2'($urandom_range(0, 3)));
                bus_read(a, v);
                e = m_read(a);
                n_tests++; if (v !== e) begin n_fail++; $display("FAIL rand_read cycle %0d addr %h: got %h want %h", c, a, v, e); end
            end
            tick();
            n_tests++; if (int_in !== m_int) begin n_fail++; $display("FAIL rand_intin cycle %0d: got %b want %b", c, int_in, m_int); end
            n_tests++; if (int_num !== m_num) begin n_fail++; $display("FAIL rand_intnum cycle %0d: got %h want %h", c, int_num, m_num); end
        end
        memwrite = 2'd0; drv_en = 1'b0;
        tick();
        quiesce();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(OFF_MASK, 32'hFF, 1, 2'd1);
        irq = '1;
        repeat (4) tick();
        n_tests++; if (int_in !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_intin: got %b want 1", int_in); end
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v !== 32'hFF) begin n_fail++; $display("FAIL rstmid_pre_pend: got %h want ff", v); end
        #1 rst = 1'b0;
        #1;
        n_tests++; if (int_in !== 1'b0) begin n_fail++; $display("FAIL rstmid_intin: got %b want 0", int_in); end
        n_tests++; if (int_num !== 32'd0) begin n_fail++; $display("FAIL rstmid_intnum: got %h want 0", int_num); end
        bus_read(reg_addr(OFF_PEND), v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL rstmid_pend: got %h want 0", v); end
        bus_read(reg_addr(OFF_MASK), v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL rstmid_mask: got %h want 0", v); end
        irq = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_held_clear();
        test_mask_during_assert();
        test_bus();
        test_set_wins();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
